// File: rtl/locked_prio_intc_pkg.sv
// Shared types and constants for the locked priority interrupt controller.
package locked_intc_pkg;

  // Raw state encodings, kept as plain constants for older tooling.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PRESENT = ST_PRESENT,
    SERVICE = ST_SERVICE
  } intc_state_e;

  // Embedded key the serial key register must hold for exact eligibility.
  localparam logic [5:0] DEFAULT_KEY = 6'b101101;

endpackage

// File: rtl/locked_prio_intc_if.sv
// Request, configuration and CPU handshake signals of the interrupt controller.
interface locked_prio_intc_if #(
  parameter int NUM_CH = 27
);
  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] req;
  logic              mask_we;
  logic [NUM_CH-1:0] mask_wdata;
  logic              key_shift;
  logic              key_in;
  logic              irq_valid;
  logic [ID_W-1:0]   irq_id;
  logic              irq_ack;
  logic              eoi;
  logic              busy;
  logic [NUM_CH-1:0] pending;

  // Controller side.
  modport slave (
    input  req, mask_we, mask_wdata, key_shift, key_in, irq_ack, eoi,
    output irq_valid, irq_id, busy, pending
  );

  // CPU / request source side.
  modport master (
    output req, mask_we, mask_wdata, key_shift, key_in, irq_ack, eoi,
    input  irq_valid, irq_id, busy, pending
  );
endinterface

// File: rtl/locked_prio_intc_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module prio_enc #(
  parameter int NUM_CH = 27,
  localparam int ID_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] v,
  output logic              any,
  output logic [ID_W-1:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) begin
        any = 1'b1;
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/locked_prio_intc.sv
// Key-locked priority interrupt controller: edge-latched pending bits,
// software mask, lowest-index grant via valid/ack/EOI handshake.
//
// state   | meaning
// IDLE    | waiting for any eligible channel
// PRESENT | irq_id frozen and offered to the CPU, waiting for ack
// SERVICE | channel acknowledged, waiting for end-of-interrupt
module locked_prio_intc
  import locked_intc_pkg::*;
#(
  parameter int               NUM_CH      = 27,
  parameter int               KEY_W       = 6,
  parameter logic [KEY_W-1:0] KEY_CORRECT = KEY_W'(DEFAULT_KEY)
) (
  input logic                clk,
  input logic                rst,
  locked_prio_intc_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] req_q;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] elig;
  logic [KEY_W-1:0]  key_q;
  logic [KEY_W-1:0]  key_err;
  logic [1:0]        state;
  logic              irq_valid;
  logic              busy;
  logic [ID_W-1:0]   irq_id;
  logic              win_any;
  logic [ID_W-1:0]   win_idx;

  assign rise    = bus.req & ~req_q;
  assign key_err = key_q ^ KEY_CORRECT;
  // Only an ack taken while presenting clears the presented channel.
  assign clr     = (state == ST_PRESENT && bus.irq_ack) ? (NUM_CH'(1) << irq_id) : '0;

  // Any wrong key bit flips eligibility of every channel mapped onto it.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = (pend[i] & ~mask[i]) ^ key_err[i % KEY_W];
    end
  end

  prio_enc #(.NUM_CH(NUM_CH)) u_prio_enc (
    .v   (elig),
    .any (win_any),
    .idx (win_idx)
  );

  // Request history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= bus.req;
  end

  // Pending bits: a fresh edge wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= rise | (pend & ~clr);
  end

  // Mask register, all channels disabled out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              mask <= '1;
    else if (bus.mask_we) mask <= bus.mask_wdata;
  end

  // Serial key register, shifted in from the MSB end.
  generate
    if (KEY_W == 1) begin : g_key1
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                key_q <= '0;
        else if (bus.key_shift) key_q <= bus.key_in;
      end
    end else begin : g_keyn
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                key_q <= '0;
        else if (bus.key_shift) key_q <= {bus.key_in, key_q[KEY_W-1:1]};
      end
    end
  endgenerate

  // Grant handshake; no preemption once a channel is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            irq_id    <= win_idx;
            irq_valid <= 1'b1;
            state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (bus.irq_ack) begin
            irq_valid <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (bus.eoi) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          irq_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_valid = irq_valid;
  assign bus.irq_id    = irq_id;
  assign bus.busy      = busy;
  assign bus.pending   = pend;

endmodule

// File: tb/tb_locked_prio_intc.sv
// Randomised and directed bench for locked_prio_intc against a behavioural model.
module tb_locked_prio_intc;

  localparam int N  = 27;
  localparam int KW = 6;
  localparam logic [KW-1:0] KC = 6'b101101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  locked_prio_intc_if #(.NUM_CH(N)) bus();

  locked_prio_intc #(.NUM_CH(N), .KEY_W(KW), .KEY_CORRECT(KC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit [N-1:0]  m_req_prev;
  bit [N-1:0]  m_pend;
  bit [N-1:0]  m_mask;
  bit [KW-1:0] m_key;
  int          m_phase;   // 0 waiting, 1 offering, 2 in service
  bit          m_valid;
  bit [4:0]    m_id;
  bit          m_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req_prev = '0; m_pend = '0; m_mask = '1; m_key = '0;
    m_phase = 0; m_valid = 0; m_id = '0; m_busy = 0;
  endtask

  // One clock edge of the specified behaviour, using inputs seen at the edge.
  task automatic model_step();
    int winner = -1;
    int cleared = -1;
    bit [N-1:0] nxt;
    for (int i = 0; i < N; i++) begin
      bit want = m_pend[i] && !m_mask[i];
      bit flip = (m_key[i % KW] != KC[i % KW]);
      if ((want != flip) && winner < 0) winner = i;
    end
    if (m_phase == 0) begin
      if (winner >= 0) begin m_valid = 1; m_id = 5'(winner); m_phase = 1; end
    end else if (m_phase == 1) begin
      if (bus.irq_ack) begin cleared = m_id; m_valid = 0; m_busy = 1; m_phase = 2; end
    end else begin
      if (bus.eoi) begin m_busy = 0; m_phase = 0; end
    end
    for (int i = 0; i < N; i++) begin
      bit new_edge = bus.req[i] && !m_req_prev[i];
      nxt[i] = new_edge || (m_pend[i] && i != cleared);
    end
    m_pend = nxt;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    if (bus.key_shift) m_key = {bus.key_in, m_key[KW-1:1]};
    m_req_prev = bus.req;
  endtask

  task automatic compare_all();
    chk("irq_valid", 64'(bus.irq_valid), 64'(m_valid));
    chk("irq_id",    64'(bus.irq_id),    64'(m_id));
    chk("busy",      64'(bus.busy),      64'(m_busy));
    chk("pending",   64'(bus.pending),   64'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.mask_we = 0; bus.mask_wdata = '0; bus.key_shift = 0;
    bus.key_in = 0; bus.irq_ack = 0; bus.eoi = 0;
  endtask

  // Asserts reset off the clock edge and checks outputs clear immediately.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    model_reset();
    chk("rst_valid",   64'(bus.irq_valid), 64'd0);
    chk("rst_busy",    64'(bus.busy),      64'd0);
    chk("rst_id",      64'(bus.irq_id),    64'd0);
    chk("rst_pending", 64'(bus.pending),   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_req(input int ch);
    bus.req[ch] = 1'b1; step(); bus.req[ch] = 1'b0;
  endtask

  task automatic ack_eoi();
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    bus.eoi = 1;     step(); bus.eoi = 0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    bus.mask_we = 1; bus.mask_wdata = m; step(); bus.mask_we = 0;
  endtask

  // Reset, load the correct key LSB-first, open the mask, flush spurious grant.
  task automatic setup_clean();
    logic [KW-1:0] kbits;
    kbits = KC;
    do_reset();
    for (int i = 0; i < KW; i++) begin
      bus.key_shift = 1; bus.key_in = kbits[i]; step();
    end
    bus.key_shift = 0;
    write_mask('0);
    ack_eoi();
    step();
    chk("clean_valid", 64'(bus.irq_valid), 64'd0);
    chk("clean_busy",  64'(bus.busy),      64'd0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    setup_clean();

    // Single request on channel 5.
    pulse_req(5);
    chk("c5_pend", 64'(bus.pending[5]), 64'd1);
    step();
    chk("c5_valid", 64'(bus.irq_valid), 64'd1);
    chk("c5_id",    64'(bus.irq_id),    64'd5);
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    chk("c5_ack_pend", 64'(bus.pending[5]), 64'd0);
    chk("c5_ack_busy", 64'(bus.busy),       64'd1);
    bus.eoi = 1; step(); bus.eoi = 0;
    chk("c5_eoi_busy", 64'(bus.busy), 64'd0);

    // Simultaneous 3 and 20: lowest first.
    bus.req[3] = 1; bus.req[20] = 1; step(); bus.req = '0;
    step();
    chk("p3_id", 64'(bus.irq_id), 64'd3);
    ack_eoi();
    step();
    chk("p20_valid", 64'(bus.irq_valid), 64'd1);
    chk("p20_id",    64'(bus.irq_id),    64'd20);
    ack_eoi();

    // Masked channel 3 stays pending until unmasked.
    write_mask(N'(1) << 3);
    pulse_req(3);
    step();
    chk("m3_valid", 64'(bus.irq_valid),   64'd0);
    chk("m3_pend",  64'(bus.pending[3]),  64'd1);
    write_mask('0);
    step();
    chk("m3_grant", 64'(bus.irq_valid), 64'd1);
    chk("m3_id",    64'(bus.irq_id),    64'd3);
    ack_eoi();

    // No preemption of channel 7 by channel 2.
    pulse_req(7);
    step();
    pulse_req(2);
    step();
    chk("np_id", 64'(bus.irq_id), 64'd7);
    ack_eoi();
    step();
    chk("np_id2", 64'(bus.irq_id), 64'd2);
    ack_eoi();

    // Ack collides with a fresh edge on the same channel.
    pulse_req(4);
    step();
    chk("col_id", 64'(bus.irq_id), 64'd4);
    bus.irq_ack = 1; bus.req[4] = 1; step(); bus.irq_ack = 0; bus.req[4] = 0;
    chk("col_pend", 64'(bus.pending[4]), 64'd1);
    chk("col_busy", 64'(bus.busy),       64'd1);
    bus.eoi = 1; step(); bus.eoi = 0;
    step();
    chk("col_re_id",    64'(bus.irq_id),    64'd4);
    chk("col_re_valid", 64'(bus.irq_valid), 64'd1);
    ack_eoi();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      bus.req        = bus.req ^ (N'($urandom) & N'($urandom) & N'($urandom));
      bus.irq_ack    = ($urandom_range(0, 3) == 0);
      bus.eoi        = ($urandom_range(0, 3) == 0);
      bus.mask_we    = ($urandom_range(0, 15) == 0);
      bus.mask_wdata = N'($urandom) & N'($urandom);
      bus.key_shift  = (c < 700) && ($urandom_range(0, 40) == 0);
      bus.key_in     = 1'($urandom);
      step();
    end
    clear_inputs();

    // Wrong key: spurious grant of channel 0, then reset mid-service.
    do_reset();
    write_mask('0);
    step();
    chk("wk_valid", 64'(bus.irq_valid), 64'd1);
    chk("wk_id",    64'(bus.irq_id),    64'd0);
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    chk("wk_busy", 64'(bus.busy), 64'd1);
    do_reset();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
